gpr_dump_tx: RTL and testbench



---
 rtl/gpr_dump_tx.sv | 108 ++++++++++
 tb/tb_gpr_dump_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump_tx.sv
//============================================================================
// Module      : gpr_dump_tx
// Description : Walks every general-purpose register through a spare read
//               port and streams {index, value} pairs over valid/ready.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module gpr_dump_tx #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_index,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          w_capture;
    logic [AW-1:0] r_out_index;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_capture   = 1'b1;
                w_state_nxt = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (out_ready) begin
                    if (r_out_last) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + AW'(1);
                        w_state_nxt = c_ST_FETCH;
                    end
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // The read address is the index register itself, so it only moves on
    // entry to a dump or after a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                r_out_index <= r_idx;
                r_out_data  <= rf_data;
                r_out_last  <= (r_idx == c_LAST_IDX);
            end
        end
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = (r_state == c_ST_SEND);
    assign done      = (r_state == c_ST_DONE);
    assign rf_addr   = r_idx;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_gpr_dump_tx.sv
//============================================================================
// Module      : tb_gpr_dump_tx
// Description : Directed self-checking bench for gpr_dump_tx.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_gpr_dump_tx;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] exp_data [NREGS];

    int n_tests;
    int n_fail;

    gpr_dump_tx #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    assign rf_data = regs[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < NREGS; i++) begin
            regs[i]     = 32'h1000_0000 + i;
            exp_data[i] = 32'h1000_0000 + i;
        end
    endtask

    // mode 0: ready=1; 1: random ready with 10-cycle stalls;
    // 2: start re-pulsed at word 5; 3: regs[3] overwritten while word 3 stalls
    task automatic run_dump(input int mode, input int exp_busy);
        int  n;
        int  busy_cyc;
        int  done_cnt;
        int  done_cyc;
        int  last_hs;
        int  stall;
        int  cyc;
        bit  fin;
        logic r;
        n = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1; last_hs = -10;
        stall = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("fetch0_busy", busy, 1);
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!busy) begin
                fin = 1;
            end else begin
                busy_cyc++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_valid_low", out_valid, 0);
                end
                if (out_valid) begin
                    if (n < NREGS) begin
                        check("word_index", out_index, n);
                        check("word_data", out_data, exp_data[n]);
                        check("word_last", out_last, (n == NREGS - 1));
                    end else begin
                        check("extra_word", n, NREGS - 1);
                    end
                end else if (!done) begin
                    check("fetch_rf_addr", rf_addr, n);
                end
                case (mode)
                    1: r = ((n == 10 || n == 20) && stall < 10) ? 1'b0 : (($urandom % 3) != 0);
                    3: r = (n == 3 && stall < 3) ? 1'b0 : 1'b1;
                    default: r = 1'b1;
                endcase
                if (mode == 3 && n == 3 && out_valid && stall == 1) regs[3] = 32'h0;
                start = (mode == 2 && n == 5 && out_valid);
                out_ready = r;
                if (out_valid && !r) stall++;
                if (out_valid && r) begin
                    if (n == NREGS - 1) last_hs = cyc;
                    n++;
                    stall = 0;
                end
            end
        end
        if (!fin) check("dump_timeout", 0, 1);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || out_valid || busy) check("post_dump_quiet", {done, out_valid, busy}, 0);
        end
        check("word_count", n, NREGS);
        check("done_count", done_cnt, 1);
        check("done_after_last", done_cyc, last_hs + 1);
        if (exp_busy > 0) check("busy_cycles", busy_cyc, exp_busy);
    endtask

    initial begin
        int found;
        int done_cnt;
        int done_cyc;
        logic prev_busy;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        preload();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_index", out_index, 0);
        check("rst_data", out_data, 0);

        run_dump(0, 65);
        run_dump(1, 0);
        run_dump(2, 65);

        regs[3] = 32'hDEAD_BEEF; exp_data[3] = 32'hDEAD_BEEF;
        run_dump(3, 68);
        preload();

        // reset while word 17 is presented
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            if (out_valid && out_index == 17) found = 1;
            else @(negedge clk);
        end
        check("reach_idx17", found, 1);
        out_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", {busy, out_valid, out_last, done, rf_addr, out_index, out_data}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || busy) check("abort_stays_idle", {done, busy}, 0);
        end
        run_dump(0, 65);

        // start held high: back-to-back dumps, one idle cycle after each done
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        done_cnt = 0; done_cyc = -100; prev_busy = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (busy && !prev_busy && done_cyc >= 0) check("b2b_gap", c - done_cyc, 2);
            prev_busy = busy;
        end
        start = 1'b0;
        check("b2b_done_count", done_cnt, 3);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        check("b2b_drain", found, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
